// File: rtl/axi_arbiter_if.sv
// AXI3 request/response bundle types and the arbiter-side interface grouping the
// per-requester bundles with the shared external master port.
package axi_arbiter_pkg;

   typedef struct packed {
      logic [3:0]  arid;
      logic [31:0] araddr;
      logic [3:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        arvalid;
      logic [3:0]  awid;
      logic [31:0] awaddr;
      logic [3:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awvalid;
      logic [3:0]  wid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        rready;
      logic        bready;
   } axi_req_t;

   typedef struct packed {
      logic        arready;
      logic [3:0]  rid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
      logic        awready;
      logic        wready;
      logic [3:0]  bid;
      logic [1:0]  bresp;
      logic        bvalid;
   } axi_resp_t;

endpackage

interface axi_arbiter_if #(parameter int NUM_REQ = 3);
   import axi_arbiter_pkg::*;

   axi_req_t  [NUM_REQ-1:0] req;
   axi_resp_t [NUM_REQ-1:0] resp;
   axi_req_t                m_req;
   axi_resp_t               m_resp;

   // slave: the arbiter's view; master: the requesters plus the external port model
   modport slave  (input req, output resp, output m_req, input m_resp);
   modport master (output req, input resp, input m_req, output m_resp);

endinterface

// File: rtl/axi_arbiter.sv
// Three-requester AXI3 arbiter: independent read and write channels, one outstanding
// transaction each. Define AXI_ARB_RR_EN for round-robin, otherwise fixed priority 2 > 1 > 0.
module axi_arbiter
   import axi_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic        clk,
   input  logic        reset,
   axi_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

   r_state_t r_state, r_state_next;
   w_state_t w_state, w_state_next;
   idx_t     rgrant, rgrant_next;
   idx_t     wgrant, wgrant_next;
   idx_t     r_win, w_win;

   logic [NUM_REQ-1:0] ar_pending;
   logic [NUM_REQ-1:0] aw_pending;

   logic win_arvalid, win_rready;
   logic win_awvalid, win_wvalid, win_wlast, win_bready;
   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

   always_comb begin
      ar_pending = '0;
      aw_pending = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ar_pending[i] = bus.req[i].arvalid;
         aw_pending[i] = bus.req[i].awvalid;
      end
   end

`ifdef AXI_ARB_RR_EN
   idx_t r_ptr, w_ptr;

   // Search upward from the pointer, wrapping, so the last winner goes to the back.
   function automatic idx_t pick(input logic [NUM_REQ-1:0] pending, input idx_t ptr);
      int   idx;
      logic found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && pending[idx]) begin
            pick  = idx_t'(idx);
            found = 1'b1;
         end
      end
   endfunction

   function automatic idx_t next_ptr(input idx_t win);
      return (int'(win) == NUM_REQ - 1) ? '0 : win + idx_t'(1);
   endfunction

   assign r_win = pick(ar_pending, r_ptr);
   assign w_win = pick(aw_pending, w_ptr);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
         w_ptr <= '0;
      end else begin
         if (r_state == R_IDLE && |ar_pending) r_ptr <= next_ptr(r_win);
         if (w_state == W_IDLE && |aw_pending) w_ptr <= next_ptr(w_win);
      end
   end
`else
   // Highest index wins: uncached over dcache over icache.
   function automatic idx_t pick(input logic [NUM_REQ-1:0] pending);
      pick = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pending[k]) pick = idx_t'(k);
      end
   endfunction

   assign r_win = pick(ar_pending);
   assign w_win = pick(aw_pending);
`endif

   assign win_arvalid = bus.req[rgrant].arvalid;
   assign win_rready  = bus.req[rgrant].rready;
   assign win_awvalid = bus.req[wgrant].awvalid;
   assign win_wvalid  = bus.req[wgrant].wvalid;
   assign win_wlast   = bus.req[wgrant].wlast;
   assign win_bready  = bus.req[wgrant].bready;

   assign ar_hs = (r_state == R_ADDR) && win_arvalid && bus.m_resp.arready;
   assign r_hs  = (r_state == R_DATA) && bus.m_resp.rvalid && win_rready;
   assign aw_hs = (w_state == W_ADDR) && win_awvalid && bus.m_resp.awready;
   assign w_hs  = (w_state == W_DATA) && win_wvalid && bus.m_resp.wready;
   assign b_hs  = (w_state == W_RESP) && bus.m_resp.bvalid && win_bready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= R_IDLE;
         rgrant  <= '0;
         w_state <= W_IDLE;
         wgrant  <= '0;
      end else begin
         r_state <= r_state_next;
         rgrant  <= rgrant_next;
         w_state <= w_state_next;
         wgrant  <= wgrant_next;
      end
   end

   // A grant is only taken in IDLE and is held until the last beat/response completes.
   always_comb begin
      r_state_next = r_state;
      rgrant_next  = rgrant;
      case (r_state)
         R_IDLE: begin
            if (|ar_pending) begin
               rgrant_next  = r_win;
               r_state_next = R_ADDR;
            end
         end
         R_ADDR:  if (ar_hs) r_state_next = R_DATA;
         R_DATA:  if (r_hs && bus.m_resp.rlast) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_next = w_state;
      wgrant_next  = wgrant;
      case (w_state)
         W_IDLE: begin
            if (|aw_pending) begin
               wgrant_next  = w_win;
               w_state_next = W_ADDR;
            end
         end
         W_ADDR:  if (aw_hs) w_state_next = W_DATA;
         W_DATA:  if (w_hs && win_wlast) w_state_next = W_RESP;
         W_RESP:  if (b_hs) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // Payload follows the current grant; valids/readies come only from registered state.
   always_comb begin
      bus.m_req         = '0;
      bus.m_req.arid    = bus.req[rgrant].arid;
      bus.m_req.araddr  = bus.req[rgrant].araddr;
      bus.m_req.arlen   = bus.req[rgrant].arlen;
      bus.m_req.arsize  = bus.req[rgrant].arsize;
      bus.m_req.arburst = bus.req[rgrant].arburst;
      bus.m_req.arvalid = (r_state == R_ADDR) && win_arvalid;
      bus.m_req.rready  = (r_state == R_DATA) && win_rready;
      bus.m_req.awid    = bus.req[wgrant].awid;
      bus.m_req.awaddr  = bus.req[wgrant].awaddr;
      bus.m_req.awlen   = bus.req[wgrant].awlen;
      bus.m_req.awsize  = bus.req[wgrant].awsize;
      bus.m_req.awburst = bus.req[wgrant].awburst;
      bus.m_req.awvalid = (w_state == W_ADDR) && win_awvalid;
      bus.m_req.wid     = bus.req[wgrant].wid;
      bus.m_req.wdata   = bus.req[wgrant].wdata;
      bus.m_req.wstrb   = bus.req[wgrant].wstrb;
      bus.m_req.wlast   = win_wlast;
      bus.m_req.wvalid  = (w_state == W_DATA) && win_wvalid;
      bus.m_req.bready  = (w_state == W_RESP) && win_bready;
   end

   // Data and IDs are broadcast; only the granted requester sees valid/ready.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.resp[i]       = '0;
         bus.resp[i].rid   = bus.m_resp.rid;
         bus.resp[i].rdata = bus.m_resp.rdata;
         bus.resp[i].rresp = bus.m_resp.rresp;
         bus.resp[i].rlast = bus.m_resp.rlast;
         bus.resp[i].bid   = bus.m_resp.bid;
         bus.resp[i].bresp = bus.m_resp.bresp;
         if (idx_t'(i) == rgrant) begin
            bus.resp[i].arready = (r_state == R_ADDR) && bus.m_resp.arready;
            bus.resp[i].rvalid  = (r_state == R_DATA) && bus.m_resp.rvalid;
         end
         if (idx_t'(i) == wgrant) begin
            bus.resp[i].awready = (w_state == W_ADDR) && bus.m_resp.awready;
            bus.resp[i].wready  = (w_state == W_DATA) && bus.m_resp.wready;
            bus.resp[i].bvalid  = (w_state == W_RESP) && bus.m_resp.bvalid;
         end
      end
   end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: reset, single read, contention, write sequencing,
// concurrent channels, backpressure and mid-burst reset. Honours AXI_ARB_RR_EN.
module tb_axi_arbiter;
   import axi_arbiter_pkg::*;

   localparam int NUM_REQ = 3;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   axi_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   axi_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] arready_vec();
      logic [NUM_REQ-1:0] v;
      for (int i = 0; i < NUM_REQ; i++) v[i] = bus.resp[i].arready;
      return v;
   endfunction

   function automatic logic [NUM_REQ-1:0] rvalid_vec();
      logic [NUM_REQ-1:0] v;
      for (int i = 0; i < NUM_REQ; i++) v[i] = bus.resp[i].rvalid;
      return v;
   endfunction

   function automatic logic [NUM_REQ-1:0] awready_vec();
      logic [NUM_REQ-1:0] v;
      for (int i = 0; i < NUM_REQ; i++) v[i] = bus.resp[i].awready;
      return v;
   endfunction

   function automatic logic [NUM_REQ-1:0] wready_vec();
      logic [NUM_REQ-1:0] v;
      for (int i = 0; i < NUM_REQ; i++) v[i] = bus.resp[i].wready;
      return v;
   endfunction

   function automatic logic [NUM_REQ-1:0] bvalid_vec();
      logic [NUM_REQ-1:0] v;
      for (int i = 0; i < NUM_REQ; i++) v[i] = bus.resp[i].bvalid;
      return v;
   endfunction

   function automatic logic [31:0] all_valids();
      return {12'd0, bus.m_req.arvalid, bus.m_req.rready, bus.m_req.awvalid,
              bus.m_req.wvalid, bus.m_req.bready, arready_vec(), rvalid_vec(),
              awready_vec(), wready_vec(), bvalid_vec()};
   endfunction

   // One single-beat read from IDLE through completion with m_resp.arready held high.
   task automatic read_grant(input int w);
      cyc();
      check_output("ct_winner_addr", bus.m_req.araddr, 32'h2000_0000 + 32'(w) * 32'h100);
      check_output("ct_arready_route", 32'(arready_vec()), 32'(1) << w);
      cyc();
      bus.req[w].arvalid   = 1'b0;
      bus.m_resp.rvalid    = 1'b1;
      bus.m_resp.rlast     = 1'b1;
      bus.m_resp.rdata     = 32'hBEEF_0000 + 32'(w);
      settle();
      check_output("ct_rvalid_route", 32'(rvalid_vec()), 32'(1) << w);
      cyc();
      bus.m_resp.rvalid = 1'b0;
      bus.m_resp.rlast  = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      bus.req     = '0;
      bus.m_resp  = '0;
      reset       = 1'b1;
      cyc();
      cyc();
      check_output("reset_valids", all_valids(), 32'd0);
      reset = 1'b0;

      // Single icache read, 4 beats
      bus.req[0].arid    = 4'h1;
      bus.req[0].araddr  = 32'h1FC0_0000;
      bus.req[0].arlen   = 4'd3;
      bus.req[0].arsize  = 3'd2;
      bus.req[0].arburst = 2'd1;
      bus.req[0].arvalid = 1'b1;
      bus.req[0].rready  = 1'b1;
      settle();
      check_output("rd_idle_no_arvalid", 32'(bus.m_req.arvalid), 32'd0);
      cyc();
      check_output("rd_arvalid_t1", 32'(bus.m_req.arvalid), 32'd1);
      check_output("rd_araddr", bus.m_req.araddr, 32'h1FC0_0000);
      check_output("rd_arlen", 32'(bus.m_req.arlen), 32'd3);
      check_output("rd_arready_gated", 32'(arready_vec()), 32'd0);
      bus.m_resp.arready = 1'b1;
      settle();
      check_output("rd_arready_route", 32'(arready_vec()), 32'b001);
      cyc();
      bus.req[0].arvalid = 1'b0;
      bus.m_resp.arready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.m_resp.rvalid = 1'b1;
         bus.m_resp.rid    = 4'h1;
         bus.m_resp.rdata  = 32'hA5A5_0000 + 32'(b);
         bus.m_resp.rlast  = (b == 3);
         settle();
         check_output("rd_beat_rvalid", 32'(rvalid_vec()), 32'b001);
         check_output("rd_beat_rdata", bus.resp[0].rdata, 32'hA5A5_0000 + 32'(b));
         check_output("rd_rid_broadcast", 32'(bus.resp[2].rid), 32'h1);
         check_output("rd_beat_rready", 32'(bus.m_req.rready), 32'd1);
         cyc();
      end
      bus.m_resp.rvalid = 1'b0;
      bus.m_resp.rlast  = 1'b0;
      settle();
      check_output("rd_back_idle", all_valids(), 32'd0);

      // Contention on the read channel from a fresh reset
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req[i].araddr  = 32'h2000_0000 + 32'(i) * 32'h100;
         bus.req[i].arlen   = 4'd0;
         bus.req[i].arvalid = 1'b1;
         bus.req[i].rready  = 1'b1;
      end
      bus.m_resp.arready = 1'b1;
`ifdef AXI_ARB_RR_EN
      read_grant(0);
      read_grant(1);
      read_grant(2);
`else
      read_grant(2);
      read_grant(1);
      read_grant(0);
`endif
      bus.req[0].arvalid = 1'b1;
      bus.req[1].arvalid = 1'b1;
`ifdef AXI_ARB_RR_EN
      read_grant(0);
      read_grant(1);
`else
      read_grant(1);
      read_grant(0);
`endif
      bus.m_resp.arready = 1'b0;

      // Dcache write, 8 beats, W held valid before AW is accepted
      bus.req[1].awid    = 4'h2;
      bus.req[1].awaddr  = 32'h0000_1000;
      bus.req[1].awlen   = 4'd7;
      bus.req[1].awsize  = 3'd2;
      bus.req[1].awburst = 2'd1;
      bus.req[1].awvalid = 1'b1;
      bus.req[1].wid     = 4'h2;
      bus.req[1].wdata   = 32'hD000_0000;
      bus.req[1].wstrb   = 4'hF;
      bus.req[1].wlast   = 1'b0;
      bus.req[1].wvalid  = 1'b1;
      bus.req[1].bready  = 1'b1;
      bus.m_resp.wready  = 1'b1;
      settle();
      check_output("wr_idle_no_wvalid", 32'(bus.m_req.wvalid), 32'd0);
      cyc();
      check_output("wr_awvalid", 32'(bus.m_req.awvalid), 32'd1);
      check_output("wr_awaddr", bus.m_req.awaddr, 32'h0000_1000);
      check_output("wr_w_blocked", 32'(bus.m_req.wvalid), 32'd0);
      check_output("wr_wready_gated", 32'(wready_vec()), 32'd0);
      bus.m_resp.awready = 1'b1;
      settle();
      check_output("wr_awready_route", 32'(awready_vec()), 32'b010);
      check_output("wr_w_still_blocked", 32'(bus.m_req.wvalid), 32'd0);
      cyc();
      bus.req[1].awvalid = 1'b0;
      bus.m_resp.awready = 1'b0;
      for (int b = 0; b < 8; b++) begin
         bus.req[1].wdata = 32'hD000_0000 + 32'(b);
         bus.req[1].wlast = (b == 7);
         settle();
         check_output("wr_beat_wvalid", 32'(bus.m_req.wvalid), 32'd1);
         check_output("wr_beat_wdata", bus.m_req.wdata, 32'hD000_0000 + 32'(b));
         check_output("wr_beat_wready", 32'(wready_vec()), 32'b010);
         cyc();
      end
      bus.req[1].wvalid = 1'b0;
      bus.req[1].wlast  = 1'b0;
      bus.m_resp.wready = 1'b0;
      bus.m_resp.bvalid = 1'b1;
      bus.m_resp.bid    = 4'h2;
      bus.m_resp.bresp  = 2'b00;
      settle();
      check_output("wr_bready", 32'(bus.m_req.bready), 32'd1);
      check_output("wr_bvalid_route", 32'(bvalid_vec()), 32'b010);
      check_output("wr_bid_broadcast", 32'(bus.resp[0].bid), 32'h2);
      cyc();
      bus.m_resp.bvalid = 1'b0;
      settle();
      check_output("wr_back_idle", all_valids(), 32'd0);

      // Uncached write and icache read at the same time
      bus.req[2].awid    = 4'h3;
      bus.req[2].awaddr  = 32'h1FAF_F000;
      bus.req[2].awlen   = 4'd0;
      bus.req[2].awvalid = 1'b1;
      bus.req[2].wdata   = 32'hC0DE_0001;
      bus.req[2].wlast   = 1'b1;
      bus.req[2].wvalid  = 1'b1;
      bus.req[2].bready  = 1'b1;
      bus.req[0].arid    = 4'h5;
      bus.req[0].araddr  = 32'h1FC0_0100;
      bus.req[0].arlen   = 4'd0;
      bus.req[0].arvalid = 1'b1;
      bus.m_resp.arready = 1'b1;
      bus.m_resp.awready = 1'b1;
      cyc();
      check_output("cc_araddr", bus.m_req.araddr, 32'h1FC0_0100);
      check_output("cc_awaddr", bus.m_req.awaddr, 32'h1FAF_F000);
      check_output("cc_arready_route", 32'(arready_vec()), 32'b001);
      check_output("cc_awready_route", 32'(awready_vec()), 32'b100);
      cyc();
      bus.req[0].arvalid = 1'b0;
      bus.req[2].awvalid = 1'b0;
      bus.m_resp.arready = 1'b0;
      bus.m_resp.awready = 1'b0;
      bus.m_resp.rvalid  = 1'b1;
      bus.m_resp.rlast   = 1'b1;
      bus.m_resp.wready  = 1'b1;
      settle();
      check_output("cc_rvalid_route", 32'(rvalid_vec()), 32'b001);
      check_output("cc_wready_route", 32'(wready_vec()), 32'b100);
      check_output("cc_wdata", bus.m_req.wdata, 32'hC0DE_0001);
      cyc();
      bus.m_resp.rvalid = 1'b0;
      bus.m_resp.rlast  = 1'b0;
      bus.m_resp.wready = 1'b0;
      bus.req[2].wvalid = 1'b0;
      bus.req[2].wlast  = 1'b0;
      bus.m_resp.bvalid = 1'b1;
      bus.m_resp.bid    = 4'h3;
      settle();
      check_output("cc_bvalid_route", 32'(bvalid_vec()), 32'b100);
      check_output("cc_read_idle", 32'(rvalid_vec()), 32'd0);
      cyc();
      bus.m_resp.bvalid = 1'b0;

      // Address backpressure for 5 cycles
      bus.req[2].arid    = 4'h7;
      bus.req[2].araddr  = 32'h1FAF_0040;
      bus.req[2].arlen   = 4'd1;
      bus.req[2].arvalid = 1'b1;
      bus.req[2].rready  = 1'b1;
      cyc();
      for (int k = 0; k < 5; k++) begin
         check_output("bp_arvalid", 32'(bus.m_req.arvalid), 32'd1);
         check_output("bp_araddr", bus.m_req.araddr, 32'h1FAF_0040);
         check_output("bp_arready", 32'(arready_vec()), 32'd0);
         cyc();
      end
      bus.m_resp.arready = 1'b1;
      settle();
      check_output("bp_arready_route", 32'(arready_vec()), 32'b100);
      cyc();
      bus.req[2].arvalid = 1'b0;
      bus.m_resp.arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.m_resp.rvalid = 1'b1;
         bus.m_resp.rlast  = (b == 1);
         settle();
         check_output("bp_rvalid_route", 32'(rvalid_vec()), 32'b100);
         cyc();
      end
      bus.m_resp.rvalid = 1'b0;
      bus.m_resp.rlast  = 1'b0;

      // Reset in the middle of a read burst and a write burst
      bus.req[0].araddr  = 32'h1FC0_0200;
      bus.req[0].arlen   = 4'd3;
      bus.req[0].arvalid = 1'b1;
      bus.req[1].awaddr  = 32'h0000_2000;
      bus.req[1].awlen   = 4'd3;
      bus.req[1].awvalid = 1'b1;
      bus.req[1].wvalid  = 1'b1;
      bus.m_resp.arready = 1'b1;
      bus.m_resp.awready = 1'b1;
      cyc();
      cyc();
      bus.req[0].arvalid = 1'b0;
      bus.req[1].awvalid = 1'b0;
      bus.m_resp.arready = 1'b0;
      bus.m_resp.awready = 1'b0;
      bus.m_resp.rvalid  = 1'b1;
      bus.m_resp.wready  = 1'b1;
      cyc();
      cyc();
      settle();
      check_output("rst_mid_burst_rvalid", 32'(rvalid_vec()), 32'b001);
      check_output("rst_mid_burst_wready", 32'(wready_vec()), 32'b010);
      reset = 1'b1;
      cyc();
      check_output("rst_all_idle", all_valids(), 32'd0);
      reset             = 1'b0;
      bus.m_resp.rvalid = 1'b0;
      bus.m_resp.wready = 1'b0;
      bus.req[1].wvalid = 1'b0;
      settle();
      check_output("rst_idle_after", all_valids(), 32'd0);
      bus.req[1].araddr  = 32'h3000_0000;
      bus.req[1].arvalid = 1'b1;
      cyc();
      check_output("rst_fresh_arvalid", 32'(bus.m_req.arvalid), 32'd1);
      check_output("rst_fresh_araddr", bus.m_req.araddr, 32'h3000_0000);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
